// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder: RV32I
//               load/store func3 encodings, the handshake FSM state type and
//               the cycle-counter MMIO address.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Load encodings (func3 with we=0)
    localparam logic [2:0] C_F3_LB  = 3'b000;
    localparam logic [2:0] C_F3_LH  = 3'b001;
    localparam logic [2:0] C_F3_LW  = 3'b010;
    localparam logic [2:0] C_F3_LBU = 3'b100;
    localparam logic [2:0] C_F3_LHU = 3'b101;

    // Store encodings (func3 with we=1)
    localparam logic [2:0] C_F3_SB  = 3'b000;
    localparam logic [2:0] C_F3_SH  = 3'b001;
    localparam logic [2:0] C_F3_SW  = 3'b010;

    // Read-only free-running cycle counter location
    localparam logic [31:0] C_MMIO_CYCLE_ADDR = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane
// Description : Combinational byte-lane logic. Extracts and sign/zero-extends
//               load data from the addressed word, builds store byte enables
//               and the lane-replicated store word, and flags illegal func3
//               codes and misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wr_word,
    output logic        o_func_err,
    output logic        o_align_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half-word from the stored word
    always_comb begin
        w_byte = i_rd_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rd_word[7:0];
            2'd1:    w_byte = i_rd_word[15:8];
            2'd2:    w_byte = i_rd_word[23:16];
            default: w_byte = i_rd_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    end

    // Decode width/sign for loads and lane enables for stores
    always_comb begin
        o_load_data = '0;
        o_be        = 4'b0000;
        o_wr_word   = '0;
        o_func_err  = 1'b0;
        o_align_err = 1'b0;
        if (i_we) begin
            case (i_func3)
                C_F3_SB: begin
                    o_be      = 4'b0001 << i_addr_lo;
                    o_wr_word = {4{i_wdata[7:0]}};
                end
                C_F3_SH: begin
                    o_align_err = i_addr_lo[0];
                    o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wr_word   = {2{i_wdata[15:0]}};
                end
                C_F3_SW: begin
                    o_align_err = (i_addr_lo != 2'd0);
                    o_be        = 4'b1111;
                    o_wr_word   = i_wdata;
                end
                default: o_func_err = 1'b1;
            endcase
        end else begin
            case (i_func3)
                C_F3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
                C_F3_LBU: o_load_data = {24'd0, w_byte};
                C_F3_LH: begin
                    o_align_err = i_addr_lo[0];
                    o_load_data = {{16{w_half[15]}}, w_half};
                end
                C_F3_LHU: begin
                    o_align_err = i_addr_lo[0];
                    o_load_data = {16'd0, w_half};
                end
                C_F3_LW: begin
                    o_align_err = (i_addr_lo != 2'd0);
                    o_load_data = i_rd_word;
                end
                default: o_func_err = 1'b1;
            endcase
        end
    end

endmodule : dmem_lane
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Word-organised data memory for an RV32I memory stage with a
//               req/ack/stall handshake and WAIT_STATES programmable stall
//               cycles. Byte/half/word loads and stores, fault reporting on
//               misalignment, illegal func3 and out-of-range addresses.
//               Optional feature macro DMEM_CYCLE_CNT_EN: maps a free-running
//               32-bit cycle counter at 0xFFFF_FF00 (LW reads it, stores are
//               silently ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        stall,
    output logic        err
);

    localparam int          C_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  C_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] C_DEPTH     = 32'(DEPTH_WORDS);
    localparam logic        C_NO_WAIT   = (WAIT_STATES == 0);

    dmem_state_e r_state, w_state_nxt;
    logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        w_latch;
    logic        w_access;

    logic        r_we;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_acc_we;
    logic [2:0]  w_acc_func3;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [C_IDX_W-1:0] w_idx;
    logic        w_in_range;
    logic [31:0] w_rd_word;

    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_wr_word;
    logic        w_func_err;
    logic        w_align_err;

    logic        w_mmio_hit;
    logic        w_mmio_rd;
    logic        w_mmio_wr;
    logic [31:0] w_cycle_val;
    logic        w_err;
    logic        w_mem_we;

    logic [31:0] r_rdata;
    logic        r_err;

    // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_latch        = 1'b0;
        w_access       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (C_NO_WAIT) begin
                        w_access    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_latch        = 1'b1;
                        w_wait_cnt_nxt = C_WAIT_LAST;
                        w_state_nxt    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, wait counter and captured request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_func3    <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_latch) begin
                r_we    <= we;
                r_func3 <= func3;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
        end
    end

    // Zero-wait accesses use the live request; otherwise the captured copy
    always_comb begin
        w_acc_we    = r_we;
        w_acc_func3 = r_func3;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_acc_we    = we;
            w_acc_func3 = func3;
            w_acc_addr  = addr;
            w_acc_wdata = wdata;
        end
    end

    assign w_idx      = w_acc_addr[C_IDX_W+1:2];
    assign w_in_range = ({2'b00, w_acc_addr[31:2]} < C_DEPTH);
    assign w_rd_word  = r_mem[w_idx];

    dmem_lane u_lane (
        .i_we        (w_acc_we),
        .i_func3     (w_acc_func3),
        .i_addr_lo   (w_acc_addr[1:0]),
        .i_rd_word   (w_rd_word),
        .i_wdata     (w_acc_wdata),
        .o_load_data (w_load_data),
        .o_be        (w_be),
        .o_wr_word   (w_wr_word),
        .o_func_err  (w_func_err),
        .o_align_err (w_align_err)
    );

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign w_mmio_hit  = (w_acc_addr == C_MMIO_CYCLE_ADDR);
    assign w_cycle_val = r_cycle_cnt;
`else
    assign w_mmio_hit  = 1'b0;
    assign w_cycle_val = '0;
`endif

    assign w_mmio_rd = w_mmio_hit & ~w_acc_we & (w_acc_func3 == C_F3_LW);
    assign w_mmio_wr = w_mmio_hit & w_acc_we & ~w_func_err;
    assign w_err     = ~(w_mmio_rd | w_mmio_wr) & (w_func_err | w_align_err | ~w_in_range);
    // rst gating keeps a zero-wait access from writing while reset is held
    assign w_mem_we  = w_access & rst & w_acc_we & ~w_err & ~w_mmio_wr;

    // Array write through the store byte enables; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
                end
            end
        end
    end

    // Response data and fault flag, updated only on an access edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_err <= w_err;
            if (w_err || w_acc_we) begin
                r_rdata <= '0;
            end else if (w_mmio_rd) begin
                r_rdata <= w_cycle_val;
            end else begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;
    assign ack   = (r_state == ST_RESP);
    assign stall = ((r_state == ST_IDLE) & req) | (r_state == ST_WAIT);

endmodule : data_mem_resp
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Self-checking bench for data_mem_resp. One instance with one
//               wait state for the functional/fault/reset sequences and one
//               zero-wait instance for back-to-back handshakes. Expected
//               responses are queued when a request is driven and compared
//               when ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ack, stall, err;

    logic        z_req = 1'b0, z_we = 1'b0;
    logic [2:0]  z_func3 = 3'd0;
    logic [31:0] z_addr = '0, z_wdata = '0;
    logic [31:0] z_rdata;
    logic        z_ack, z_stall, z_err;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          tb_cyc  = 0;
    int          last_cyc = 0;
    logic [31:0] last_rdata = '0;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .func3(func3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .stall(stall), .err(err)
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dutz (
        .clk(clk), .rst(rst), .req(z_req), .we(z_we), .func3(z_func3), .addr(z_addr),
        .wdata(z_wdata), .rdata(z_rdata), .ack(z_ack), .stall(z_stall), .err(z_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access on the one-wait-state instance; starts just after a posedge
    task automatic acc(input string tag, input logic i_we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic chk_data, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int   stalls;
        logic got_ack;
        e.d = exp_d;
        e.e = exp_e;
        q.push_back(e);
        req = 1'b1; we = i_we; func3 = f3; addr = a; wdata = wd;
        stalls  = 0;
        got_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack) begin
                got_ack = 1'b1;
                break;
            end
            if (stall) stalls++;
            @(posedge clk);
            #1;
        end
        check({tag, " ack"}, 32'(got_ack), 32'd1);
        e = q.pop_front();
        check({tag, " stall_cycles"}, 32'(stalls), 32'd2);
        check({tag, " stall_in_resp"}, 32'(stall), 32'd0);
        check({tag, " err"}, 32'(err), 32'(e.e));
        if (chk_data || e.e) check({tag, " rdata"}, rdata, e.d);
        last_rdata = rdata;
        last_cyc   = tb_cyc;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check({tag, " ack_one_cycle"}, 32'(ack), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v1;
    int          c1;
    logic        zt_we [4];
    logic [2:0]  zt_f3 [4];
    logic [31:0] zt_a  [4];
    logic [31:0] zt_wd [4];
    logic [31:0] zt_exp[4];

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst rdata", rdata, 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst ack", 32'(ack), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        check("rst z_ack", 32'(z_ack), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Word store/load and byte lanes
        acc("sw_10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        acc("lw_10",   1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        acc("sb_13",   1'b1, 3'b000, 32'h13, 32'h80, 1'b0, 32'h0, 1'b0);
        acc("lb_13",   1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
        acc("lbu_13",  1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0);
        acc("lw_10b",  1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
        acc("lh_12",   1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF80AD, 1'b0);
        acc("lhu_12",  1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h000080AD, 1'b0);
        acc("lb_11",   1'b0, 3'b000, 32'h11, 32'h0, 1'b1, 32'hFFFFFFBE, 1'b0);

        // Faults: no write, rdata forced to zero
        acc("lh_11",   1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
        acc("sh_11",   1'b1, 3'b001, 32'h11, 32'hFFFF, 1'b0, 32'h0, 1'b1);
        acc("sw_12",   1'b1, 3'b010, 32'h12, 32'h11111111, 1'b0, 32'h0, 1'b1);
        acc("st_f3_4", 1'b1, 3'b100, 32'h10, 32'h22222222, 1'b0, 32'h0, 1'b1);
        acc("ld_f3_3", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
        acc("lw_10c",  1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
        acc("lw_oor",  1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 1'b1, 32'h0, 1'b1);
        acc("sw_last", 1'b1, 3'b010, 32'(DEPTH * 4 - 4), 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        acc("lw_last", 1'b0, 3'b010, 32'(DEPTH * 4 - 4), 32'h0, 1'b1, 32'h0BADF00D, 1'b0);

        // Reset while a store waits: the store must be dropped
        acc("sw_20",   1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        req = 1'b1; we = 1'b1; func3 = 3'b010; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        check("abort stall_idle", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check("abort stall_wait", 32'(stall), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("abort stall_rst", 32'(stall), 32'd0);
        check("abort ack_rst", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        check("abort ack_after_edge", 32'(ack), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        acc("lw_20",   1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

        // Cycle-counter location
`ifdef DMEM_CYCLE_CNT_EN
        acc("cnt_rd1", 1'b0, 3'b010, 32'hFFFFFF00, 32'h0, 1'b0, 32'h0, 1'b0);
        v1 = last_rdata;
        c1 = last_cyc;
        repeat (5) @(posedge clk);
        #1;
        acc("cnt_rd2", 1'b0, 3'b010, 32'hFFFFFF00, 32'h0, 1'b0, 32'h0, 1'b0);
        check("cnt delta", last_rdata - v1, 32'(last_cyc - c1));
        acc("cnt_wr",  1'b1, 3'b010, 32'hFFFFFF00, 32'h5, 1'b0, 32'h0, 1'b0);
`else
        acc("cnt_rd",  1'b0, 3'b010, 32'hFFFFFF00, 32'h0, 1'b1, 32'h0, 1'b1);
        acc("cnt_wr",  1'b1, 3'b010, 32'hFFFFFF00, 32'h5, 1'b0, 32'h0, 1'b1);
`endif

        // Zero-wait instance: back-to-back requests with req held high
        zt_we[0] = 1'b1; zt_f3[0] = 3'b010; zt_a[0] = 32'h40; zt_wd[0] = 32'h11223344; zt_exp[0] = 32'h0;
        zt_we[1] = 1'b0; zt_f3[1] = 3'b010; zt_a[1] = 32'h40; zt_wd[1] = 32'h0; zt_exp[1] = 32'h11223344;
        zt_we[2] = 1'b0; zt_f3[2] = 3'b101; zt_a[2] = 32'h42; zt_wd[2] = 32'h0; zt_exp[2] = 32'h00001122;
        zt_we[3] = 1'b0; zt_f3[3] = 3'b000; zt_a[3] = 32'h43; zt_wd[3] = 32'h0; zt_exp[3] = 32'h00000011;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.d = zt_exp[i];
            e.e = 1'b0;
            q.push_back(e);
            z_req = 1'b1; z_we = zt_we[i]; z_func3 = zt_f3[i]; z_addr = zt_a[i]; z_wdata = zt_wd[i];
            @(negedge clk);
            check($sformatf("z%0d stall_idle", i), 32'(z_stall), 32'd1);
            check($sformatf("z%0d ack_idle", i), 32'(z_ack), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            e = q.pop_front();
            check($sformatf("z%0d ack_resp", i), 32'(z_ack), 32'd1);
            check($sformatf("z%0d stall_resp", i), 32'(z_stall), 32'd0);
            check($sformatf("z%0d err", i), 32'(z_err), 32'(e.e));
            if (!zt_we[i]) check($sformatf("z%0d rdata", i), z_rdata, e.d);
            @(posedge clk);
            #1;
        end
        z_req = 1'b0; z_we = 1'b0;
        @(negedge clk);
        check("z idle ack", 32'(z_ack), 32'd0);
        check("z idle stall", 32'(z_stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_mem_resp
`default_nettype wire
